// File: rtl/audio_play_sched_pkg.sv
// Shared constants and types for the two-channel sample playback scheduler.
package audio_play_sched_pkg;

  localparam logic [7:0] SILENCE = 8'h80;  // excess-128 mid-scale
  localparam int NUM_CH = 2;
  localparam int CH_L   = 0;
  localparam int CH_R   = 1;

  // Fetch arbiter: one shared memory read takes IDLE -> READ -> WAIT.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/audio_play_sched_if.sv
// Sample memory bus: registered single-port read, data one cycle after strobe.
interface audio_play_sched_if #(
  parameter int ADDR_W = 12
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (output mem_rd, output mem_addr, input  mem_data);
  modport slave  (input  mem_rd, input  mem_addr, output mem_data);
endinterface

// File: rtl/audio_play_chan.sv
// One playback channel: address walk, loop reload, pending flag, DAC sample.
module audio_play_chan
  import audio_play_sched_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              i_tick,
  input  logic              i_go,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_start,
  input  logic [ADDR_W-1:0] i_len,
  input  logic              i_loop,
  input  logic              i_wr,      // arbiter is in WAIT for this channel
  input  logic [7:0]        i_data,
  output logic [ADDR_W-1:0] o_ptr,
  output logic              o_pending,
  output logic              o_active,
  output logic              o_done,
  output logic [7:0]        o_sample
);

  logic [ADDR_W-1:0] r_ptr, r_rem, r_base, r_len;
  logic              r_loop, r_active, r_pending, r_done;
  logic [7:0]        r_sample;
  logic              w_go, w_commit, w_last;

  // A zero-length go is no go at all, so it must not cancel a fetch either.
  assign w_go     = i_go && (i_len != '0);
  // Pending is still set only if no stop/go touched the channel since the tick;
  // a go or stop in the WAIT cycle itself also discards the returning byte.
  assign w_commit = i_wr && r_pending && !w_go && !i_stop;
  assign w_last   = (r_rem == ADDR_W'(1));

  // Channel state: tick scheduling, fetch commit, then stop/go override.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_ptr     <= '0;
      r_rem     <= '0;
      r_base    <= '0;
      r_len     <= '0;
      r_loop    <= 1'b0;
      r_active  <= 1'b0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
      r_sample  <= SILENCE;
    end else begin
      r_done <= 1'b0;
      if (i_tick) begin
        if (r_active) r_pending <= 1'b1;
        else          r_sample  <= SILENCE;
      end
      if (w_commit) begin
        r_sample  <= i_data;
        r_pending <= 1'b0;
        r_ptr     <= r_ptr + 1'b1;
        r_rem     <= r_rem - 1'b1;
        if (w_last) begin
          if (r_loop) begin
            r_ptr <= r_base;
            r_rem <= r_len;
          end else begin
            r_active <= 1'b0;
            r_done   <= 1'b1;
          end
        end
      end
      // Stop beats go; both beat a coincident tick.
      if (i_stop) begin
        r_active  <= 1'b0;
        r_pending <= 1'b0;
      end else if (w_go) begin
        r_ptr     <= i_start;
        r_base    <= i_start;
        r_rem     <= i_len;
        r_len     <= i_len;
        r_loop    <= i_loop;
        r_active  <= 1'b1;
        r_pending <= 1'b0;
      end
    end
  end

  assign o_ptr     = r_ptr;
  assign o_pending = r_pending;
  assign o_active  = r_active;
  assign o_done    = r_done;
  assign o_sample  = r_sample;

endmodule

// File: rtl/audio_play_sched.sv
// Two-channel playback scheduler: prescaler, round-robin fetch arbiter, memory mux.
module audio_play_sched
  import audio_play_sched_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DIV    = 7000,
  parameter int CNT_W  = 13
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              i_go_l,
  input  logic              i_go_r,
  input  logic              i_stop_l,
  input  logic              i_stop_r,
  input  logic [ADDR_W-1:0] i_start_l,
  input  logic [ADDR_W-1:0] i_start_r,
  input  logic [ADDR_W-1:0] i_len_l,
  input  logic [ADDR_W-1:0] i_len_r,
  input  logic              i_loop_l,
  input  logic              i_loop_r,
  audio_play_sched_if.master mem,
  output logic [7:0]        o_sample_l,
  output logic [7:0]        o_sample_r,
  output logic              o_active_l,
  output logic              o_active_r,
  output logic              o_done_l,
  output logic              o_done_r
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;
  fetch_state_e     r_state, w_state_nxt;
  logic             r_sel, w_sel_nxt, r_rr, w_rr_nxt;
  logic             w_mem_rd;
  logic [ADDR_W-1:0] w_mem_addr;

  logic [NUM_CH-1:0]             w_go, w_stop, w_loop, w_wr, w_pend, w_act, w_done;
  logic [NUM_CH-1:0][ADDR_W-1:0] w_start, w_len, w_ptr;
  logic [NUM_CH-1:0][7:0]        w_smp;

  assign w_go[CH_L]    = i_go_l;     assign w_go[CH_R]    = i_go_r;
  assign w_stop[CH_L]  = i_stop_l;   assign w_stop[CH_R]  = i_stop_r;
  assign w_loop[CH_L]  = i_loop_l;   assign w_loop[CH_R]  = i_loop_r;
  assign w_start[CH_L] = i_start_l;  assign w_start[CH_R] = i_start_r;
  assign w_len[CH_L]   = i_len_l;    assign w_len[CH_R]   = i_len_r;

  assign w_tick = (r_cnt == CNT_W'(DIV - 1));

  // Sample-rate prescaler, one tick per DIV clocks.
  always_ff @(posedge clk) begin
    if (Reset)       r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    audio_play_chan #(.ADDR_W(ADDR_W)) u_chan (
      .clk      (clk),
      .Reset    (Reset),
      .i_tick   (w_tick),
      .i_go     (w_go[g]),
      .i_stop   (w_stop[g]),
      .i_start  (w_start[g]),
      .i_len    (w_len[g]),
      .i_loop   (w_loop[g]),
      .i_wr     (w_wr[g]),
      .i_data   (mem.mem_data),
      .o_ptr    (w_ptr[g]),
      .o_pending(w_pend[g]),
      .o_active (w_act[g]),
      .o_done   (w_done[g]),
      .o_sample (w_smp[g])
    );
  end

  // Arbiter state, selected channel and round-robin pointer.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  // Next-state and bus drive; the pointer only flips when both channels contend.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_rr_nxt    = r_rr;
    w_mem_rd    = 1'b0;
    w_mem_addr  = '0;
    w_wr        = '0;
    case (r_state)
      ST_IDLE: begin
        if (|w_pend) begin
          w_state_nxt = ST_READ;
          if (&w_pend) begin
            w_sel_nxt = r_rr;
            w_rr_nxt  = ~r_rr;
          end else begin
            w_sel_nxt = w_pend[CH_R];
          end
        end
      end
      ST_READ: begin
        w_mem_rd    = 1'b1;
        w_mem_addr  = w_ptr[r_sel];
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_wr[r_sel] = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign mem.mem_rd   = w_mem_rd;
  assign mem.mem_addr = w_mem_addr;

  assign o_sample_l = w_smp[CH_L];
  assign o_sample_r = w_smp[CH_R];
  assign o_active_l = w_act[CH_L];
  assign o_active_r = w_act[CH_R];
  assign o_done_l   = w_done[CH_L];
  assign o_done_r   = w_done[CH_R];

endmodule

// File: tb/tb_audio_play_sched.sv
// Bench for audio_play_sched: event-schedule reference model, directed and random stimulus.
module tb_audio_play_sched;

  localparam int ADDR_W = 12;
  localparam int DIV    = 8;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]             go = '0, stop = '0, lp = '0;
  logic [1:0][ADDR_W-1:0] start = '0, len = '0;
  logic [7:0]             smp_l, smp_r;
  logic                   act_l, act_r, dn_l, dn_r;

  audio_play_sched_if #(.ADDR_W(ADDR_W)) bus();

  audio_play_sched #(.ADDR_W(ADDR_W), .DIV(DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .Reset(rst),
    .i_go_l(go[0]), .i_go_r(go[1]), .i_stop_l(stop[0]), .i_stop_r(stop[1]),
    .i_start_l(start[0]), .i_start_r(start[1]), .i_len_l(len[0]), .i_len_r(len[1]),
    .i_loop_l(lp[0]), .i_loop_r(lp[1]),
    .mem(bus),
    .o_sample_l(smp_l), .o_sample_r(smp_r), .o_active_l(act_l), .o_active_r(act_r),
    .o_done_l(dn_l), .o_done_r(dn_r)
  );

  // Sample memory: synchronous read, data one cycle after the strobe.
  logic [7:0] mem [0:4095];
  always @(posedge clk) if (bus.mem_rd === 1'b1) bus.mem_data <= mem[bus.mem_addr];

  int n_vec = 0, n_err = 0;

  // Reference model: per-channel architectural state plus a schedule of the
  // cycle numbers at which the shared read and its commit happen.
  int cyc = 0, rd_cyc = -100, wr_cyc = -100, free_cyc = 0, fch = 0;
  int unsigned m_cnt = 0;
  bit m_rr;
  bit m_act[2], m_pend[2], m_loop[2], m_done[2];
  logic [ADDR_W-1:0] m_ptr[2], m_rem[2], m_base[2], m_len[2];
  logic [7:0] m_smp[2];

  // Observation logs for the literal checks.
  logic [7:0]        log_l[$], log_r[$];
  logic [ADDR_W-1:0] alog[$];
  logic [7:0]        prev_l = 8'h80, prev_r = 8'h80;
  int                ndone_l = 0, ndone_r = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit tick;
    bit old_act[2];
    bit gf[2];
    if (rst) begin
      m_cnt = 0; m_rr = 0; rd_cyc = -100; wr_cyc = -100; free_cyc = cyc + 1;
      for (int c = 0; c < 2; c++) begin
        m_act[c] = 0; m_pend[c] = 0; m_done[c] = 0; m_smp[c] = 8'h80;
      end
    end else begin
      tick  = (m_cnt == DIV - 1);
      m_cnt = tick ? 0 : m_cnt + 1;
      for (int c = 0; c < 2; c++) begin
        old_act[c] = m_act[c];
        gf[c]      = go[c] && (len[c] != '0);
        m_done[c]  = 0;
      end
      // Arbiter free and something waiting: book the read and the commit.
      if (cyc >= free_cyc && (m_pend[0] || m_pend[1])) begin
        if (m_pend[0] && m_pend[1]) begin fch = m_rr ? 1 : 0; m_rr = !m_rr; end
        else fch = m_pend[1] ? 1 : 0;
        rd_cyc = cyc + 1; wr_cyc = cyc + 2; free_cyc = cyc + 3;
      end
      if (cyc == wr_cyc && m_pend[fch] && !gf[fch] && !stop[fch]) begin
        m_smp[fch]  = mem[m_ptr[fch]];
        m_pend[fch] = 0;
        if (m_rem[fch] == ADDR_W'(1)) begin
          if (m_loop[fch]) begin m_ptr[fch] = m_base[fch]; m_rem[fch] = m_len[fch]; end
          else begin m_act[fch] = 0; m_done[fch] = 1; m_ptr[fch] = m_ptr[fch] + 1'b1; end
        end else begin
          m_ptr[fch] = m_ptr[fch] + 1'b1; m_rem[fch] = m_rem[fch] - 1'b1;
        end
      end
      for (int c = 0; c < 2; c++) begin
        if (stop[c]) begin m_act[c] = 0; m_pend[c] = 0; end
        else if (gf[c]) begin
          m_ptr[c] = start[c]; m_base[c] = start[c]; m_rem[c] = len[c]; m_len[c] = len[c];
          m_loop[c] = lp[c]; m_act[c] = 1; m_pend[c] = 0;
        end else if (tick && old_act[c]) m_pend[c] = 1;
        if (tick && !old_act[c]) m_smp[c] = 8'h80;
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    logic [ADDR_W-1:0] ea;
    ea = (cyc == rd_cyc) ? m_ptr[fch] : '0;
    chk("sample_l", 32'(smp_l), 32'(m_smp[0]));
    chk("sample_r", 32'(smp_r), 32'(m_smp[1]));
    chk("active_l", 32'(act_l), 32'(m_act[0]));
    chk("active_r", 32'(act_r), 32'(m_act[1]));
    chk("done_l",   32'(dn_l),  32'(m_done[0]));
    chk("done_r",   32'(dn_r),  32'(m_done[1]));
    chk("mem_rd",   32'(bus.mem_rd),   32'(cyc == rd_cyc));
    chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
    if (smp_l !== prev_l) log_l.push_back(smp_l);
    if (smp_r !== prev_r) log_r.push_back(smp_r);
    prev_l = smp_l; prev_r = smp_r;
    if (dn_l === 1'b1) ndone_l++;
    if (dn_r === 1'b1) ndone_r++;
    if (bus.mem_rd === 1'b1) alog.push_back(bus.mem_addr);
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit later.
  task automatic clk1();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    go = '0; stop = '0;
  endtask

  task automatic run(input int n);
    repeat (n) clk1();
  endtask

  task automatic start_ch(input int c, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] l, input logic lv);
    start[c] = s; len[c] = l; lp[c] = lv; go[c] = 1'b1;
    clk1();
  endtask

  task automatic wait_rd(input logic [ADDR_W-1:0] a, input int max);
    bit hit;
    hit = 0;
    for (int i = 0; i < max && !hit; i++) begin
      clk1();
      hit = (bus.mem_rd === 1'b1) && (bus.mem_addr == a);
    end
    chk("wait_rd", 32'(hit), 32'd1);
  endtask

  task automatic chk_q8(input string nm, input logic [7:0] q[$], input int mk, input logic [7:0] e);
    chk(nm, (mk < q.size()) ? 32'(q[mk]) : 32'hDEAD, 32'(e));
  endtask

  logic [7:0]        exp_l[5]  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h80};
  logic [7:0]        exp_r[4]  = '{8'hA1, 8'hB2, 8'hA1, 8'hB2};
  logic [ADDR_W-1:0] exp_c[4]  = '{12'h200, 12'h300, 12'h301, 12'h201};
  logic [ADDR_W-1:0] exp_w[4]  = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

  initial begin
    int mk, d0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h40;
    mem[12'h100] = 8'hA1; mem[12'h101] = 8'hB2;
    mem[12'h400] = 8'h5A; mem[12'h401] = 8'h6B;

    // Reset values
    rst = 1'b1;
    run(3);
    chk("rst_sample_l", 32'(smp_l), 32'h80);
    chk("rst_mem_rd",   32'(bus.mem_rd), 32'd0);
    chk("rst_active_l", 32'(act_l), 32'd0);
    rst = 1'b0;
    run(2);

    // Left only, no loop
    mk = log_l.size(); d0 = ndone_l;
    start_ch(0, 12'h000, 12'd4, 1'b0);
    run(6 * DIV);
    for (int i = 0; i < 5; i++) chk_q8("left_seq", log_l, mk + i, exp_l[i]);
    chk("left_done_cnt", 32'(ndone_l - d0), 32'd1);
    chk("left_inactive", 32'(act_l), 32'd0);

    // Right loop
    mk = log_r.size(); d0 = ndone_r;
    start_ch(1, 12'h100, 12'd2, 1'b1);
    run(6 * DIV);
    for (int i = 0; i < 4; i++) chk_q8("loop_seq", log_r, mk + i, exp_r[i]);
    chk("loop_no_done", 32'(ndone_r - d0), 32'd0);
    chk("loop_active",  32'(act_r), 32'd1);
    stop[1] = 1'b1; clk1();
    run(DIV + 1);

    // Contention
    mk = alog.size();
    start[0] = 12'h200; len[0] = 12'd8; lp[0] = 1'b0;
    start[1] = 12'h300; len[1] = 12'd8; lp[1] = 1'b0;
    go = 2'b11; clk1();
    run(3 * DIV);
    for (int i = 0; i < 4; i++)
      chk("contend_addr", (mk + i < alog.size()) ? 32'(alog[mk + i]) : 32'hDEAD, 32'(exp_c[i]));
    stop = 2'b11; clk1();
    run(DIV + 1);

    // Stop during the WAIT of the second left fetch
    d0 = ndone_l;
    start_ch(0, 12'h400, 12'd4, 1'b0);
    wait_rd(12'h401, 3 * DIV);
    clk1();                          // WAIT cycle
    stop[0] = 1'b1; clk1();
    chk("stop_hold", 32'(smp_l), 32'h5A);
    run(DIV);
    chk("stop_silence", 32'(smp_l), 32'h80);
    chk("stop_no_done", 32'(ndone_l - d0), 32'd0);

    // Address wrap
    mk = alog.size();
    start_ch(0, 12'hFFE, 12'd4, 1'b0);
    run(6 * DIV);
    for (int i = 0; i < 4; i++)
      chk("wrap_addr", (mk + i < alog.size()) ? 32'(alog[mk + i]) : 32'hDEAD, 32'(exp_w[i]));

    // Zero-length go ignored; go+stop together leaves channel idle
    start_ch(0, 12'h010, 12'd0, 1'b0);
    chk("len0_inactive", 32'(act_l), 32'd0);
    start[0] = 12'h020; len[0] = 12'd3; go[0] = 1'b1; stop[0] = 1'b1; clk1();
    chk("gostop_inactive", 32'(act_l), 32'd0);

    // Reset during a READ cycle
    start_ch(1, 12'h500, 12'd3, 1'b0);
    wait_rd(12'h500, 3 * DIV);
    rst = 1'b1; clk1();
    chk("rr_mem_rd",   32'(bus.mem_rd), 32'd0);
    chk("rr_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rr_sample_r", 32'(smp_r), 32'h80);
    chk("rr_active_r", 32'(act_r), 32'd0);
    rst = 1'b0;
    run(2);

    // Random traffic
    repeat (3000) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 39) == 0) begin
          start[c] = ADDR_W'($urandom);
          len[c]   = ($urandom_range(0, 4) == 0) ? '0 : ADDR_W'($urandom_range(1, 6));
          lp[c]    = 1'($urandom_range(0, 1));
          go[c]    = 1'b1;
        end
        if ($urandom_range(0, 59) == 0) stop[c] = 1'b1;
      end
      rst = ($urandom_range(0, 799) == 0);
      clk1();
    end
    rst = 1'b0;
    run(2 * DIV);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
